// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared types and constants for the HI/LO register pair and its multiply/divide engine.
package hilo_muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MTHI,
        MTLO,
        MULT,
        MULTU,
        DIV,
        DIVU
    } hilo_op_t;

    // State names carry a prefix so they cannot collide with the DIV opcode.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV
    } hilo_state_t;

    // Divide by zero fills LO with this bit; signed overflow fills HI with this bit.
    localparam logic DIV0_QUO_FILL = 1'b1;
    localparam logic OVF_REM_FILL  = 1'b0;

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the execute stage (master) and the HI/LO unit (slave).
interface hilo_muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
);
    import hilo_muldiv_unit_pkg::*;

    logic                  req_valid;
    hilo_op_t              req_op;
    logic [DATA_WIDTH-1:0] req_a;
    logic [DATA_WIDTH-1:0] req_b;
    logic                  req_ready;
    logic                  flush;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;

    modport master (
        output req_valid, req_op, req_a, req_b, flush,
        input  req_ready, busy, done, hi, lo
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, flush,
        output req_ready, busy, done, hi, lo
    );

endinterface

// File: rtl/hilo_muldiv_unit_iter_divider.sv
// Radix-2 restoring divider: one quotient bit per clock on operand magnitudes, sign fixup on the last step.
module hilo_muldiv_unit_iter_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  signed_op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);
    import hilo_muldiv_unit_pkg::*;

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v,
                                                         input logic is_signed);
        return (is_signed && v[DATA_WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sign_fix(input logic [DATA_WIDTH-1:0] v,
                                                        input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] rem_q, quo_q, dsr_q, a_q;
    logic                  neg_quo_q, neg_rem_q, div0_q, ovf_q;
    logic [DATA_WIDTH:0]   rem_sh, trial;
    logic [DATA_WIDTH-1:0] rem_nx, quo_nx;

    // Iteration step: shift in the next dividend bit, keep the trial difference if non-negative.
    always_comb begin
        rem_sh = {rem_q, quo_q[DATA_WIDTH-1]};
        trial  = rem_sh - {1'b0, dsr_q};
        if (trial[DATA_WIDTH]) begin
            rem_nx = rem_sh[DATA_WIDTH-1:0];
            quo_nx = {quo_q[DATA_WIDTH-2:0], 1'b0};
        end else begin
            rem_nx = trial[DATA_WIDTH-1:0];
            quo_nx = {quo_q[DATA_WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt_q <= '0;
        else if (abort)
            cnt_q <= '0;
        else if (start)
            cnt_q <= CNT_W'(DATA_WIDTH);
        else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (start) begin
            rem_q     <= '0;
            quo_q     <= magnitude(a, signed_op);
            dsr_q     <= magnitude(b, signed_op);
            a_q       <= a;
            neg_quo_q <= signed_op && (a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1]);
            neg_rem_q <= signed_op && a[DATA_WIDTH-1];
            div0_q    <= (b == '0);
            ovf_q     <= signed_op && (a == MOST_NEG) && (b == '1);
        end else if (cnt_q != '0) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
        end
    end

    assign done = (cnt_q == CNT_W'(1)) && !abort;

    always_comb begin
        if (div0_q) begin
            quotient  = {DATA_WIDTH{DIV0_QUO_FILL}};
            remainder = a_q;
        end else if (ovf_q) begin
            quotient  = a_q;
            remainder = {DATA_WIDTH{OVF_REM_FILL}};
        end else begin
            quotient  = sign_fix(quo_nx, neg_quo_q);
            remainder = sign_fix(rem_nx, neg_rem_q);
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Architectural HI/LO pair with MTHI/MTLO writes and multi-cycle MULT/MULTU/DIV/DIVU engine.
module hilo_muldiv_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int MUL_LATENCY = 3
) (
    input logic                clk,
    input logic                resetn,
    hilo_muldiv_unit_if.slave  bus
);
    import hilo_muldiv_unit_pkg::*;

    localparam int MCNT_W = 4;

    hilo_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0]   hi_q, lo_q, hi_d, lo_d;
    logic                    done_q, wr_res;
    logic                    accept, mul_start, div_start, mul_signed, div_signed;
    logic [MCNT_W-1:0]       mul_cnt_q;
    logic [2*DATA_WIDTH-1:0] product_q;
    logic signed [2*DATA_WIDTH-1:0] mul_a_ext, mul_b_ext, product_now;
    logic                    div_done;
    logic [DATA_WIDTH-1:0]   div_quo, div_rem;

    assign accept     = bus.req_valid && bus.req_ready && !bus.flush;
    assign mul_signed = (bus.req_op == MULT);
    assign div_signed = (bus.req_op == DIV);

    // Extending both operands to 2W bits makes one signed multiply serve MULT and MULTU.
    assign mul_a_ext   = signed'({{DATA_WIDTH{mul_signed & bus.req_a[DATA_WIDTH-1]}}, bus.req_a});
    assign mul_b_ext   = signed'({{DATA_WIDTH{mul_signed & bus.req_b[DATA_WIDTH-1]}}, bus.req_b});
    assign product_now = mul_a_ext * mul_b_ext;

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        wr_res    = 1'b0;
        mul_start = 1'b0;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (bus.req_op)
                        MTHI: hi_d = bus.req_a;
                        MTLO: lo_d = bus.req_a;
                        MULT, MULTU: begin
                            if (MUL_LATENCY == 1) begin
                                {hi_d, lo_d} = product_now;
                                wr_res       = 1'b1;
                            end else begin
                                mul_start = 1'b1;
                                state_d   = ST_MUL;
                            end
                        end
                        DIV, DIVU: begin
                            div_start = 1'b1;
                            state_d   = ST_DIV;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (mul_cnt_q == MCNT_W'(1)) begin
                    {hi_d, lo_d} = product_q;
                    wr_res       = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (div_done) begin
                    hi_d    = div_rem;
                    lo_d    = div_quo;
                    wr_res  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            mul_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= wr_res;
            if (mul_start)
                mul_cnt_q <= MCNT_W'(MUL_LATENCY - 1);
            else if (state_q == ST_MUL && !bus.flush)
                mul_cnt_q <= mul_cnt_q - 1'b1;
            else
                mul_cnt_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (mul_start)
            product_q <= product_now;
    end

    hilo_muldiv_unit_iter_divider #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_iter_divider (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_start),
        .abort     (bus.flush && (state_q == ST_DIV)),
        .signed_op (div_signed),
        .a         (bus.req_a),
        .b         (bus.req_b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: MTHI/MTLO, multiply, divide, boundary results, flush and reset.
module tb_hilo_muldiv_unit;
    import hilo_muldiv_unit_pkg::*;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    hilo_muldiv_unit_if #(.DATA_WIDTH(DW)) bus ();

    hilo_muldiv_unit #(
        .DATA_WIDTH  (DW),
        .MUL_LATENCY (3)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single edge, then counts edges until done is seen.
    task automatic run_op(input hilo_op_t op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          output int edges);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        tick();
        bus.req_valid = 1'b0;
        edges = 1;
        while (!bus.done && edges < 64) begin
            tick();
            edges++;
        end
    endtask

    task automatic result_case(input string tag, input hilo_op_t op, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input int exp_edges,
                               input logic [DW-1:0] exp_hi, input logic [DW-1:0] exp_lo);
        int edges;
        run_op(op, a, b, edges);
        check_val({tag, "_edges"}, 64'(edges), 64'(exp_edges));
        check_val({tag, "_hi"}, bus.hi, exp_hi);
        check_val({tag, "_lo"}, bus.lo, exp_lo);
        tick();
        check_val({tag, "_done_off"}, bus.done, 1'b0);
    endtask

    initial begin
        int done_seen;
        resetn        = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = MTHI;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.flush     = 1'b0;
        repeat (3) tick();
        check_val("rst_hi", bus.hi, 32'h0);
        check_val("rst_lo", bus.lo, 32'h0);
        check_val("rst_busy", bus.busy, 1'b0);
        check_val("rst_done", bus.done, 1'b0);
        check_val("rst_ready", bus.req_ready, 1'b1);
        resetn = 1'b1;
        tick();

        // MTHI: one edge, no busy, no done
        bus.req_valid = 1'b1;
        bus.req_op    = MTHI;
        bus.req_a     = 32'h1234_5678;
        tick();
        bus.req_valid = 1'b0;
        check_val("mthi_hi", bus.hi, 32'h1234_5678);
        check_val("mthi_lo", bus.lo, 32'h0);
        check_val("mthi_busy", bus.busy, 1'b0);
        check_val("mthi_done", bus.done, 1'b0);
        tick();
        check_val("mthi_done2", bus.done, 1'b0);

        // MULT -2 * 3 with cycle-by-cycle visibility
        bus.req_valid = 1'b1;
        bus.req_op    = MULT;
        bus.req_a     = 32'hFFFF_FFFE;
        bus.req_b     = 32'h0000_0003;
        tick();
        bus.req_valid = 1'b0;
        check_val("mult_busy1", bus.busy, 1'b1);
        check_val("mult_ready1", bus.req_ready, 1'b0);
        check_val("mult_done1", bus.done, 1'b0);
        tick();
        check_val("mult_busy2", bus.busy, 1'b1);
        check_val("mult_hi_hold", bus.hi, 32'h1234_5678);
        tick();
        check_val("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check_val("mult_lo", bus.lo, 32'hFFFF_FFFA);
        check_val("mult_busy3", bus.busy, 1'b0);
        check_val("mult_done", bus.done, 1'b1);
        tick();
        check_val("mult_done_off", bus.done, 1'b0);

        result_case("mult_mix", MULT, 32'h7FFF_FFFF, 32'h8000_0000, 3, 32'hC000_0000, 32'h8000_0000);
        result_case("multu_mix", MULTU, 32'h7FFF_FFFF, 32'h8000_0000, 3, 32'h3FFF_FFFF, 32'h8000_0000);

        result_case("div_n7_2", DIV, 32'hFFFF_FFF9, 32'h2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        result_case("div_7_n2", DIV, 32'h7, 32'hFFFF_FFFE, 33, 32'h1, 32'hFFFF_FFFD);
        result_case("divu_7_2", DIVU, 32'h7, 32'h2, 33, 32'h1, 32'h3);
        result_case("divu_by0", DIVU, 32'h55, 32'h0, 33, 32'h55, 32'hFFFF_FFFF);
        result_case("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);
        result_case("div_by0_neg", DIV, 32'hFFFF_FFFB, 32'h0, 33, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // Flush at iteration 10 of a DIV, with an MTLO presented in the same cycle
        bus.req_valid = 1'b1;
        bus.req_op    = DIV;
        bus.req_a     = 32'd100;
        bus.req_b     = 32'd7;
        tick();
        bus.req_valid = 1'b0;
        repeat (9) tick();
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = MTLO;
        bus.req_a     = 32'hAA;
        tick();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        check_val("flush_busy", bus.busy, 1'b0);
        check_val("flush_ready", bus.req_ready, 1'b1);
        check_val("flush_done", bus.done, 1'b0);
        check_val("flush_hi", bus.hi, 32'hFFFF_FFFB);
        check_val("flush_lo", bus.lo, 32'hFFFF_FFFF);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) done_seen++;
        end
        check_val("flush_no_done", 64'(done_seen), 64'd0);
        check_val("flush_lo_late", bus.lo, 32'hFFFF_FFFF);
        check_val("flush_hi_late", bus.hi, 32'hFFFF_FFFB);

        result_case("divu_after_flush", DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);

        // Asynchronous reset in the middle of a MULTU
        bus.req_valid = 1'b1;
        bus.req_op    = MULTU;
        bus.req_a     = 32'd5;
        bus.req_b     = 32'd6;
        tick();
        bus.req_valid = 1'b0;
        check_val("rstmid_busy_pre", bus.busy, 1'b1);
        resetn = 1'b0;
        #1;
        check_val("rstmid_hi", bus.hi, 32'h0);
        check_val("rstmid_lo", bus.lo, 32'h0);
        check_val("rstmid_busy", bus.busy, 1'b0);
        check_val("rstmid_ready", bus.req_ready, 1'b1);
        tick();
        resetn = 1'b1;
        repeat (4) tick();
        check_val("rstmid_lo_late", bus.lo, 32'h0);
        check_val("rstmid_done_late", bus.done, 1'b0);

        result_case("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFE, 32'h0000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
